// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : coin_dispenser
// Purpose  : Greedy coin-return engine with per-denomination hopper stock,
//            refill support and a valid/ack coin handshake.
// Revision : 1.0
// ============================================================================
module coin_dispenser #(
    parameter int                      kNumCoins  = 3,
    parameter int                      kTotalBits = 31,
    parameter logic [kTotalBits-1:0]   COIN_VAL0  = 100,
    parameter logic [kTotalBits-1:0]   COIN_VAL1  = 500,
    parameter logic [kTotalBits-1:0]   COIN_VAL2  = 1000,
    parameter int                      STOCK_BITS = 8,
    parameter logic [STOCK_BITS-1:0]   INIT_STOCK = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [kTotalBits-1:0]   i_amount,
    input  logic                    i_coin_ack,
    input  logic                    i_refill_valid,
    input  logic [kNumCoins-1:0]    i_refill_sel,
    input  logic [STOCK_BITS-1:0]   i_refill_count,
    output logic                    o_busy,
    output logic                    o_coin_valid,
    output logic [kNumCoins-1:0]    o_coin_sel,
    output logic                    o_done,
    output logic [kTotalBits-1:0]   o_remainder,
    output logic [STOCK_BITS-1:0]   o_stock0,
    output logic [STOCK_BITS-1:0]   o_stock1,
    output logic [STOCK_BITS-1:0]   o_stock2
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int                    SEL_W     = $clog2(kNumCoins);
    localparam logic [kTotalBits-1:0] COIN_VAL [kNumCoins] = '{COIN_VAL0, COIN_VAL1, COIN_VAL2};
    localparam logic [STOCK_BITS:0]   STOCK_MAX = {1'b0, {STOCK_BITS{1'b1}}};

    state_t                  state_q, state_d;
    logic [kTotalBits-1:0]   remaining_q, remaining_d;
    logic [kNumCoins-1:0]    sel_q, sel_d;
    logic [kTotalBits-1:0]   remainder_q, remainder_d;
    logic [STOCK_BITS-1:0]   stock_q [kNumCoins];
    logic [STOCK_BITS-1:0]   stock_d [kNumCoins];

    logic                    found;
    logic [SEL_W-1:0]        pick;
    logic [kNumCoins-1:0]    pick_onehot;
    logic [kTotalBits-1:0]   sel_val;

    // Ascending scan so the last match is the largest eligible denomination.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if ((COIN_VAL[k] <= remaining_q) && (stock_q[k] != '0)) begin
                found = 1'b1;
                pick  = SEL_W'(k);
            end
        end
        pick_onehot = kNumCoins'(1) << pick;
    end

    always_comb begin
        sel_val = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (sel_q[k]) begin
                sel_val = sel_val | COIN_VAL[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sel_d       = sel_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    remaining_d = i_amount;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                if (found) begin
                    sel_d   = pick_onehot;
                    state_d = DISPENSE;
                end else begin
                    // Loaded here so the value is already valid in the o_done cycle.
                    remainder_d = remaining_q;
                    state_d     = DONE;
                end
            end
            DISPENSE: begin
                if (i_coin_ack) begin
                    remaining_d = remaining_q - sel_val;
                    state_d     = SELECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Refill and dispense may hit the same counter in one cycle; saturate the net result.
    always_comb begin
        logic                 refill_ok;
        logic [STOCK_BITS:0]  sum;
        refill_ok = (i_refill_sel != '0) &&
                    ((i_refill_sel & (i_refill_sel - kNumCoins'(1))) == '0);
        sum = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            sum = {1'b0, stock_q[k]};
            if (i_refill_valid && refill_ok && i_refill_sel[k]) begin
                sum = sum + {1'b0, i_refill_count};
            end
            if ((state_q == DISPENSE) && i_coin_ack && sel_q[k]) begin
                sum = sum - (STOCK_BITS+1)'(1);
            end
            stock_d[k] = (sum > STOCK_MAX) ? STOCK_MAX[STOCK_BITS-1:0] : sum[STOCK_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sel_q       <= '0;
            remainder_q <= '0;
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= INIT_STOCK;
            end
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sel_q       <= sel_d;
            remainder_q <= remainder_d;
            for (int k = 0; k < kNumCoins; k++) begin
                stock_q[k] <= stock_d[k];
            end
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_coin_valid = (state_q == DISPENSE);
    assign o_coin_sel   = (state_q == DISPENSE) ? sel_q : '0;
    assign o_done       = (state_q == DONE);
    assign o_remainder  = remainder_q;
    assign o_stock0     = stock_q[0];
    assign o_stock1     = stock_q[1];
    assign o_stock2     = stock_q[2];

endmodule
`default_nettype wire
